// File: rtl/mem_rsp_buffer.sv
// In-order read response buffer in front of a fixed-latency memory island port.
// Turns the island's non-stallable response into a ready/valid stream.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   requester request handshake
//   req_addr_i/write_i    request address and direction (1 = write)
//   req_data_i/strb_i     write data and byte enables
//   rsp_valid_o/ready_i   read response handshake
//   rsp_data_o            read data, in request order
//   mem_req_o/mem_rsp_i   island request / response
//   outstanding_o         reads in flight plus reads buffered

package mem_rsp_buffer_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } mem_req_q_t;

    typedef struct packed {
        logic       q_valid;
        mem_req_q_t q;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] data;
    } mem_rsp_p_t;

    typedef struct packed {
        logic       q_ready;
        mem_rsp_p_t p;
    } mem_rsp_t;

endpackage

module mem_rsp_buffer
    import mem_rsp_buffer_pkg::*;
#(
    parameter type         mem_req_t = mem_rsp_buffer_pkg::mem_req_t,
    parameter type         mem_rsp_t = mem_rsp_buffer_pkg::mem_rsp_t,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 1,
    parameter int unsigned Depth     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_addr_i,
    input  logic                         req_write_i,
    input  logic [DataWidth-1:0]         req_data_i,
    input  logic [DataWidth/8-1:0]       req_strb_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DataWidth-1:0]         rsp_data_o,
    output mem_req_t                     mem_req_o,
    input  mem_rsp_t                     mem_rsp_i,
    output logic [$clog2(Depth+1)-1:0]   outstanding_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [CntW-1:0] OneC    = CntW'(1);
    localparam logic [PtrW-1:0] OneP    = PtrW'(1);

    // Credit counter and FIFO bookkeeping
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      r_fill;
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [DataWidth-1:0] r_mem [Depth];
    logic [Latency-1:0]   r_pipe;

    logic w_credit_ok;
    logic w_hs;
    logic w_rd_hs;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    // Writes bypass the credit check: they never produce a response beat.
    assign w_credit_ok = (r_cnt < DepthC) | req_write_i;

    assign req_ready_o = mem_rsp_i.q_ready & w_credit_ok & ~rst_i;
    assign w_hs        = req_valid_i & req_ready_o;
    assign w_rd_hs     = w_hs & ~req_write_i;

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == DepthC);

    // Island data is valid exactly when the tracked read leaves the pipe.
    assign w_push = r_pipe[Latency-1];
    assign w_pop  = rsp_valid_o & rsp_ready_i;

    assign rsp_valid_o   = ~w_empty;
    assign rsp_data_o    = r_mem[r_rptr];
    assign outstanding_o = r_cnt;

    always_comb begin
        mem_req_o         = '0;
        mem_req_o.q_valid = req_valid_i & w_credit_ok & ~rst_i;
        mem_req_o.q.addr  = req_addr_i;
        mem_req_o.q.write = req_write_i;
        mem_req_o.q.data  = req_data_i;
        mem_req_o.q.strb  = req_strb_i;
    end

    // Credit is taken at the read handshake and returned only at pop,
    // so a slot is always reserved for every read the island returns.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_rd_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + OneC;
                2'b01:   r_cnt <= r_cnt - OneC;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_hs;
            for (int i = 1; i < Latency; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + OneC;
                2'b01:   r_fill <= r_fill - OneC;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Pointers wrap explicitly so any Depth works, not only powers of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + OneP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + OneP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= mem_rsp_i.p.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_push && w_full));
        end
    end

endmodule

// File: tb/tb_mem_rsp_buffer.sv
// Testbench for mem_rsp_buffer: island model, scoreboard monitor,
// request-path vector table and hand-written multi-cycle sequences.

module tb_mem_rsp_buffer;
    import mem_rsp_buffer_pkg::*;

    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    mem_req_t    mem_req;
    mem_rsp_t    mem_rsp;
    logic [2:0]  outstanding_o;

    logic        isl_ready;
    logic [31:0] isl_pipe [L];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_rsp_buffer #(
        .Latency (L),
        .Depth   (D)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_write_i   (req_write_i),
        .req_data_i    (req_data_i),
        .req_strb_i    (req_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .mem_req_o     (mem_req),
        .mem_rsp_i     (mem_rsp),
        .outstanding_o (outstanding_o)
    );

    function automatic logic [31:0] isl_f(logic [31:0] a);
        return 32'hCAFE_0000 | (a >> 4);
    endfunction

    // Island: fixed L-cycle read latency, not reset.
    always @(posedge clk) begin
        isl_pipe[0] <= (mem_req.q_valid && isl_ready && !mem_req.q.write)
                       ? isl_f(mem_req.q.addr) : 32'hDEAD_BEEF;
        for (int i = 1; i < L; i++) isl_pipe[i] <= isl_pipe[i-1];
    end

    always_comb begin
        mem_rsp         = '0;
        mem_rsp.q_ready = isl_ready;
        mem_rsp.p.data  = isl_pipe[L-1];
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    logic [31:0] sb [$];
    int          m_cnt;
    initial begin
        logic        hs, pop, rd, p_valid, p_pop, p_rst;
        logic [31:0] p_data, exp_d;
        m_cnt   = 0;
        p_valid = 1'b0;
        p_pop   = 1'b0;
        p_rst   = 1'b1;
        p_data  = '0;
        forever begin
            @(negedge clk);
            hs  = req_valid_i & req_ready_o;
            rd  = hs & ~req_write_i;
            pop = rsp_valid_o & rsp_ready_i;
            chk("mon_req_ready", req_ready_o,
                !rst_i && isl_ready && (m_cnt < D || req_write_i));
            chk("mon_outstanding", outstanding_o, m_cnt);
            if (p_valid && !p_pop && !p_rst) begin
                chk("mon_hold_valid", rsp_valid_o, 1);
                chk("mon_hold_data", rsp_data_o, p_data);
            end
            if (pop) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL mon_unexpected_rsp: got %0h expected none",
                             rsp_data_o);
                end else begin
                    exp_d = sb.pop_front();
                    if (rsp_data_o === exp_d) n_pass++;
                    else $display("FAIL mon_rsp_data: got %0h expected %0h",
                                  rsp_data_o, exp_d);
                end
            end
            if (rst_i) begin
                sb.delete();
                m_cnt = 0;
            end else begin
                if (rd) sb.push_back(isl_f(req_addr_i));
                m_cnt = m_cnt + int'(rd) - int'(pop);
            end
            p_valid = rsp_valid_o;
            p_pop   = pop;
            p_rst   = rst_i;
            p_data  = rsp_data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        qr;
        logic        e_rdy;
        logic        e_qv;
    } vec_t;

    vec_t tbl [6];

    task automatic drain();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 50 && (outstanding_o != 0 || rsp_valid_o); i++)
            cyc();
        chk("drain_outstanding", outstanding_o, 0);
    endtask

    task automatic issue_reads(logic [31:0] base, int n);
        int k = 0;
        for (int c = 0; c < 20 && k < n; c++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = base + 32'(k * 16);
            #1;
            if (req_ready_o) k++;
            cyc();
        end
        req_valid_i = 1'b0;
        chk("issue_count", k, n);
    endtask

    initial begin
        int k;
        int acc;

        tbl[0] = '{1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 32'h110, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h120, 32'h1234_5678, 4'h3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h130, 32'h0BAD_F00D, 4'h8, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h140, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h150, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0};

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_data_i  = '0;
        req_strb_i  = '0;
        rsp_ready_i = 1'b1;
        isl_ready   = 1'b1;
        repeat (2) cyc();
        rst_i = 1'b0;
        #1;
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);
        chk("reset_outstanding", outstanding_o, 0);
        chk("reset_req_ready", req_ready_o, 1);
        cyc();

        // Single read: valid Latency+1 cycles after the handshake.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h10;
        #1;
        chk("single_ready", req_ready_o, 1);
        cyc();
        req_valid_i = 1'b0;
        #1;
        chk("single_out_t1", outstanding_o, 1);
        chk("single_valid_t1", rsp_valid_o, 0);
        cyc();
        #1;
        chk("single_out_t2", outstanding_o, 1);
        chk("single_valid_t2", rsp_valid_o, 0);
        cyc();
        #1;
        chk("single_valid_t3", rsp_valid_o, 1);
        chk("single_data_t3", rsp_data_o, 32'hCAFE_0001);
        chk("single_out_t3", outstanding_o, 1);
        cyc();
        #1;
        chk("single_valid_t4", rsp_valid_o, 0);
        chk("single_out_t4", outstanding_o, 0);

        // Credit stall: six reads against four credits.
        rsp_ready_i = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = 32'h20 + 32'(k * 16);
            #1;
            chk("stall_ready", req_ready_o, k < 4);
            if (req_ready_o) k++;
            cyc();
        end
        chk("stall_accepted", k, 4);
        chk("stall_outstanding", outstanding_o, 4);
        repeat (L + 1) cyc();
        rsp_ready_i = 1'b1;
        #1;
        chk("stall_pop_cycle_ready", req_ready_o, 0);
        cyc();
        #1;
        chk("stall_after_pop_ready", req_ready_o, 1);
        if (req_ready_o) k++;
        cyc();
        for (int c = 0; c < 10 && k < 6; c++) begin
            req_addr_i = 32'h20 + 32'(k * 16);
            #1;
            if (req_ready_o) k++;
            cyc();
        end
        chk("stall_all_issued", k, 6);
        drain();

        // Writes ignore credits: request-path vectors at full credit.
        rsp_ready_i = 1'b0;
        issue_reads(32'h80, 4);
        repeat (L + 1) cyc();
        chk("full_outstanding", outstanding_o, 4);
        for (int i = 0; i < 6; i++) begin
            req_valid_i = tbl[i].v;
            req_write_i = tbl[i].w;
            req_addr_i  = tbl[i].a;
            req_data_i  = tbl[i].d;
            req_strb_i  = tbl[i].s;
            isl_ready   = tbl[i].qr;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d_qvalid", i), mem_req.q_valid, tbl[i].e_qv);
            chk($sformatf("vec%0d_addr", i), mem_req.q.addr, tbl[i].a);
            chk($sformatf("vec%0d_write", i), mem_req.q.write, tbl[i].w);
            chk($sformatf("vec%0d_data", i), mem_req.q.data, tbl[i].d);
            chk($sformatf("vec%0d_strb", i), mem_req.q.strb, tbl[i].s);
            cyc();
        end
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        isl_ready   = 1'b1;
        #1;
        chk("write_outstanding", outstanding_o, 4);
        chk("write_head_valid", rsp_valid_o, 1);
        chk("write_head_data", rsp_data_o, isl_f(32'h80));
        drain();

        // Island backpressure.
        isl_ready   = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h200;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", req_ready_o, 0);
            chk("bp_outstanding", outstanding_o, 0);
            cyc();
        end
        isl_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready_o, 1);
        cyc();
        req_valid_i = 1'b0;
        #1;
        chk("bp_outstanding_after", outstanding_o, 1);
        drain();

        // Simultaneous accept and pop, then full rate across pointer wrap.
        rsp_ready_i = 1'b0;
        issue_reads(32'h300, 2);
        repeat (L + 1) cyc();
        chk("simul_pre_out", outstanding_o, 2);
        chk("simul_pre_valid", rsp_valid_o, 1);
        rsp_ready_i = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = 32'h320 + 32'(c * 16);
            #1;
            if (req_ready_o) acc++;
            cyc();
            if (c == 0) chk("simul_cnt_held", outstanding_o, 2);
        end
        chk("full_rate_accepts", acc, 10);
        drain();

        // Mid-operation reset.
        rsp_ready_i = 1'b0;
        issue_reads(32'h500, 3);
        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h530;
        #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_q_valid", mem_req.q_valid, 0);
        cyc();
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        chk("rst_after_valid", rsp_valid_o, 0);
        chk("rst_after_out", outstanding_o, 0);
        chk("rst_after_data", rsp_data_o, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk("rst_late_valid", rsp_valid_o, 0);
        end
        req_valid_i = 1'b1;
        req_addr_i  = 32'h400;
        #1;
        chk("rst_new_ready", req_ready_o, 1);
        cyc();
        req_valid_i = 1'b0;
        #1;
        chk("rst_new_valid_t1", rsp_valid_o, 0);
        cyc();
        #1;
        chk("rst_new_valid_t2", rsp_valid_o, 0);
        cyc();
        #1;
        chk("rst_new_valid_t3", rsp_valid_o, 1);
        chk("rst_new_data_t3", rsp_data_o, 32'hCAFE_0040);
        drain();

        chk("final_scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
